// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared FSM encoding and address map constants for the register file arbiter
package rf_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   localparam int          RF_ADDR_W     = 6;
   localparam logic [5:0]  RF_MAX_ADDR   = 6'h38;
   localparam logic [5:0]  RF_WPROT_BASE = 6'h30;
   localparam logic [5:0]  RF_BCAST_ALL  = 6'h01;
   localparam logic [5:0]  RF_BCAST_ROT  = 6'h02;
   localparam logic [5:0]  RF_BCAST_DRV  = 6'h03;

endpackage

// File: rtl/reg_file_arbiter_if.sv
// rtl/reg_file_arbiter_if.sv - requester and register-file port bundle for reg_file_arbiter
interface reg_file_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
);
   logic              req0_valid;
   logic              req0_write;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic              req0_rvalid;
   logic [DATA_W-1:0] req0_rdata;
   logic              req0_err;

   logic              req1_valid;
   logic              req1_write;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_ready;
   logic              req1_rvalid;
   logic [DATA_W-1:0] req1_rdata;
   logic              req1_err;

   logic [ADDR_W-1:0] rf_address;
   logic              rf_write_en;
   logic [DATA_W-1:0] rf_wr_data;
   logic              rf_read_en;
   logic [DATA_W-1:0] rf_rd_data;

   // Requesters and the register file sit on the master side; the arbiter is the slave.
   modport master (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      input  req0_ready, req0_rvalid, req0_rdata, req0_err,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req1_ready, req1_rvalid, req1_rdata, req1_err,
      input  rf_address, rf_write_en, rf_wr_data, rf_read_en,
      output rf_rd_data
   );

   modport slave (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      output req0_ready, req0_rvalid, req0_rdata, req0_err,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req1_ready, req1_rvalid, req1_rdata, req1_err,
      output rf_address, rf_write_en, rf_wr_data, rf_read_en,
      input  rf_rd_data
   );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker; last=1 means requester 1 was served last
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       update,
   output logic [1:0] grant,
   output logic       next_last
);

   always_comb begin
      grant     = 2'b00;
      next_last = last;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
      if (update && (|req)) begin
         next_last = grant[1];
      end
   end

endmodule

// File: rtl/reg_file_arbiter.sv
// rtl/reg_file_arbiter.sv - serialises two requesters onto the register file port
// Optional requester-1 write protection below WPROT_BASE: RF_ARB_WPROT_EN
module reg_file_arbiter
   import rf_arb_pkg::*;
#(
   parameter int                ADDR_W     = 6,
   parameter int                DATA_W     = 8,
   parameter int                RD_LATENCY = 1,
   parameter logic [ADDR_W-1:0] MAX_ADDR   = RF_MAX_ADDR,
   parameter logic [ADDR_W-1:0] WPROT_BASE = RF_WPROT_BASE
) (
   input  logic                clock,
   input  logic                reset_n,
   reg_file_arbiter_if.slave   bus,
   output logic                busy
);

`ifdef RF_ARB_WPROT_EN
   localparam logic WPROT_ON = 1'b1;
`else
   localparam logic WPROT_ON = 1'b0;
`endif

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic [1:0]        grant;
   logic              gnt1_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        cnt_q;
   logic              issue_err;

   rr_arb2 u_rr_arb2 (
      .req       ({bus.req1_valid, bus.req0_valid}),
      .last      (last_q),
      .update    (state_q == ST_IDLE),
      .grant     (grant),
      .next_last (last_d)
   );

   assign issue_err = (addr_q > MAX_ADDR) ||
                      (WPROT_ON && gnt1_q && wr_q && (addr_q < WPROT_BASE));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         gnt1_q  <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         case (state_q)
            ST_IDLE: begin
               if (|grant) begin
                  gnt1_q  <= grant[1];
                  wr_q    <= grant[1] ? bus.req1_write : bus.req0_write;
                  addr_q  <= grant[1] ? bus.req1_addr  : bus.req0_addr;
                  wdata_q <= grant[1] ? bus.req1_wdata : bus.req0_wdata;
               end
            end
            ST_ISSUE: begin
               // Cleared here so writes and errors respond with zero data.
               err_q   <= issue_err;
               rdata_q <= '0;
               cnt_q   <= 2'(RD_LATENCY - 1);
            end
            ST_WAIT_RD: begin
               if (cnt_q == 2'd0) begin
                  rdata_q <= bus.rf_rd_data;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rf_address = addr_q;
   assign busy           = (state_q != ST_IDLE);

   always_comb begin
      state_d         = state_q;
      bus.req0_ready  = 1'b0;
      bus.req1_ready  = 1'b0;
      bus.req0_rvalid = 1'b0;
      bus.req1_rvalid = 1'b0;
      bus.req0_rdata  = '0;
      bus.req1_rdata  = '0;
      bus.req0_err    = 1'b0;
      bus.req1_err    = 1'b0;
      bus.rf_write_en = 1'b0;
      bus.rf_read_en  = 1'b0;
      bus.rf_wr_data  = '0;
      case (state_q)
         ST_IDLE: begin
            if (|grant) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            bus.req0_ready = !gnt1_q;
            bus.req1_ready = gnt1_q;
            if (issue_err) begin
               state_d = ST_RESP;
            end else if (wr_q) begin
               bus.rf_write_en = 1'b1;
               bus.rf_wr_data  = wdata_q;
               state_d         = ST_RESP;
            end else begin
               bus.rf_read_en = 1'b1;
               state_d        = ST_WAIT_RD;
            end
         end
         ST_WAIT_RD: begin
            if (cnt_q == 2'd0) state_d = ST_RESP;
         end
         ST_RESP: begin
            bus.req0_rvalid = !gnt1_q;
            bus.req1_rvalid = gnt1_q;
            bus.req0_rdata  = gnt1_q ? '0 : rdata_q;
            bus.req1_rdata  = gnt1_q ? rdata_q : '0;
            bus.req0_err    = !gnt1_q && err_q;
            bus.req1_err    = gnt1_q && err_q;
            state_d         = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb/tb_reg_file_arbiter.sv - directed self-checking bench for reg_file_arbiter
module tb_reg_file_arbiter;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic busy;

   always #5 clock = ~clock;

   reg_file_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

   reg_file_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LATENCY(1)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus),
      .busy    (busy)
   );

   logic [7:0] mem [64];
   logic [7:0] rd_q = 8'h00;

   always @(posedge clock) begin
      if (bus.rf_read_en)  rd_q <= mem[bus.rf_address];
      if (bus.rf_write_en) mem[bus.rf_address] <= bus.rf_wr_data;
   end
   assign bus.rf_rd_data = rd_q;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic ready_of(input int who);
      return (who == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   function automatic logic rvalid_of(input int who);
      return (who == 0) ? bus.req0_rvalid : bus.req1_rvalid;
   endfunction

   function automatic logic [7:0] rdata_of(input int who);
      return (who == 0) ? bus.req0_rdata : bus.req1_rdata;
   endfunction

   function automatic logic err_of(input int who);
      return (who == 0) ? bus.req0_err : bus.req1_err;
   endfunction

   task automatic drive(input int who, input logic v, input logic wr,
                        input logic [5:0] a, input logic [7:0] d);
      if (who == 0) begin
         bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
      end else begin
         bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
      end
   endtask

   // Called at a negedge with the DUT idle; that cycle is cycle 0.
   task automatic txn(input int who, input logic wr, input logic [5:0] a,
                      input logic [7:0] d, input logic exp_err, input logic [7:0] exp_rdata);
      int cyc = 0;
      int exp_lat;
      drive(who, 1'b1, wr, a, d);
      while (!ready_of(who) && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      check("ready_latency", cyc, 1);
      check("write_en", bus.rf_write_en, wr && !exp_err);
      check("read_en", bus.rf_read_en, !wr && !exp_err);
      check("rf_address", bus.rf_address, a);
      if (wr && !exp_err) check("rf_wr_data", bus.rf_wr_data, d);
      check("other_ready", ready_of(1 - who), 0);
      drive(who, 1'b0, 1'b0, 6'h00, 8'h00);
      while (!rvalid_of(who) && cyc < 20) begin
         @(negedge clock);
         cyc++;
         if (!rvalid_of(who)) begin
            check("strobe_outside_issue", bus.rf_write_en | bus.rf_read_en, 0);
         end
      end
      exp_lat = (wr || exp_err) ? 2 : 3;
      check("rvalid_latency", cyc, exp_lat);
      check("rdata", rdata_of(who), exp_rdata);
      check("err", err_of(who), exp_err);
      check("other_rvalid", rvalid_of(1 - who), 0);
      @(negedge clock);
      check("idle_after", busy, 0);
   endtask

   initial begin
      int n;
      int cyc;
      logic seen;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      mem[6'h0F] = 8'h3C;
      mem[6'h38] = 8'h77;
      drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 6'h00, 8'h00);

      repeat (3) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
      check("rst_rvalid", {bus.req0_rvalid, bus.req1_rvalid}, 0);
      check("rst_strobes", {bus.rf_write_en, bus.rf_read_en}, 0);
      check("rst_address", bus.rf_address, 0);
      reset_n = 1'b1;
      @(negedge clock);

      txn(0, 1'b1, 6'h04, 8'hA5, 1'b0, 8'h00);
      check("mem_04", mem[6'h04], 8'hA5);
      txn(1, 1'b0, 6'h0F, 8'h00, 1'b0, 8'h3C);

      // Both held valid: grants must alternate starting with req0.
      drive(0, 1'b1, 1'b1, 6'h20, 8'h5A);
      drive(1, 1'b1, 1'b1, 6'h21, 8'hC3);
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 40) begin
         @(negedge clock);
         cyc++;
         check("one_ready", bus.req0_ready & bus.req1_ready, 0);
         check("one_rvalid", bus.req0_rvalid & bus.req1_rvalid, 0);
         check("strobe_wo_ready", (bus.rf_write_en | bus.rf_read_en) &
                                  !(bus.req0_ready | bus.req1_ready), 0);
         if (bus.req0_ready | bus.req1_ready) begin
            check("alt_grant", bus.req1_ready, n % 2);
            check("alt_strobe", bus.rf_write_en, 1);
            n++;
         end
      end
      check("alt_count", n, 4);
      drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 6'h00, 8'h00);
      repeat (2) @(negedge clock);
      check("alt_idle", busy, 0);
      check("mem_20", mem[6'h20], 8'h5A);
      check("mem_21", mem[6'h21], 8'hC3);

      txn(0, 1'b0, 6'h38, 8'h00, 1'b0, 8'h77);
      txn(0, 1'b0, 6'h3A, 8'h00, 1'b1, 8'h00);
      txn(0, 1'b1, 6'h39, 8'h55, 1'b1, 8'h00);
      txn(1, 1'b0, 6'h04, 8'h00, 1'b0, 8'hA5);
`ifdef RF_ARB_WPROT_EN
      txn(1, 1'b1, 6'h00, 8'h11, 1'b1, 8'h00);
      txn(1, 1'b1, 6'h0C, 8'h99, 1'b1, 8'h00);
      check("mem_0c", mem[6'h0C], 8'h00);
      txn(1, 1'b1, 6'h38, 8'h1F, 1'b0, 8'h00);
      txn(1, 1'b0, 6'h38, 8'h00, 1'b0, 8'h1F);
      txn(0, 1'b1, 6'h0C, 8'h42, 1'b0, 8'h00);
`else
      txn(1, 1'b1, 6'h00, 8'h11, 1'b0, 8'h00);
      txn(1, 1'b1, 6'h02, 8'h66, 1'b0, 8'h00);
      txn(1, 1'b0, 6'h02, 8'h00, 1'b0, 8'h66);
`endif

      // Reset during WAIT_RD of a req0 read, so the pointer would otherwise favour req1.
      drive(0, 1'b1, 1'b0, 6'h0F, 8'h00);
      cyc = 0;
      while (!bus.req0_ready && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      check("mid_ready", cyc, 1);
      drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
      @(negedge clock);
      check("mid_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_address", bus.rf_address, 0);
      check("mid_rst_rvalid", {bus.req0_rvalid, bus.req1_rvalid}, 0);
      check("mid_rst_strobes", {bus.rf_write_en, bus.rf_read_en}, 0);
      @(negedge clock);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clock);
         seen = seen | bus.req0_rvalid | bus.req1_rvalid;
      end
      check("no_stray_rvalid", seen, 0);
      drive(0, 1'b1, 1'b0, 6'h04, 8'h00);
      drive(1, 1'b1, 1'b0, 6'h0F, 8'h00);
      cyc = 0;
      while (!(bus.req0_ready | bus.req1_ready) && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      check("post_rst_grant0", bus.req0_ready, 1);
      check("post_rst_grant1", bus.req1_ready, 0);
      drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 6'h00, 8'h00);
      repeat (3) @(negedge clock);
      check("final_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
- Shares the single address/strobe port of the register file between two bus requesters.
  - Requester 0 is the host SPI slave.
  - Requester 1 is the UART debug console.
- Serialises accesses, generates one-cycle write_en/read_en strobes and waits out the registered read latency.
- Returns per-requester completions with an error flag.
- Sits between the host-interface blocks and the register file.

Parameters:
- ADDR_W, 6, register address width.
- DATA_W, 8, register data width.
- RD_LATENCY, 1, cycles from read strobe to valid register-file read data (1..3).
- MAX_ADDR, 6'h38, highest implemented address; above it is out of range.
- WPROT_BASE, 6'h30, lowest address requester 1 may write when write protection is compiled in.

Ports:
- clock  in  1  main clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 access request; held until req0_ready
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  register address
- req0_wdata  in  DATA_W  write data
- req0_ready  out  1  one-cycle accept pulse
- req0_rvalid  out  1  one-cycle completion pulse
- req0_rdata  out  DATA_W  read data, valid with req0_rvalid
- req0_err  out  1  error, valid with req0_rvalid
- req1_*  same set as req0_* for requester 1
- rf_address  out  ADDR_W  register file address
- rf_write_en  out  1  register file write strobe
- rf_wr_data  out  DATA_W  register file write data
- rf_read_en  out  1  register file read strobe
- rf_rd_data  in  DATA_W  register file read data, registered
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous:
  - All outputs 0; state IDLE.
  - Round-robin pointer = "req1 served last", so req0 wins the first tie.
  - Reset mid-transaction abandons it: no strobe and no rvalid for it afterwards.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - Samples both valids each cycle.
  - If one is valid, grant it; if both, grant the one not served last.
  - Latch write, addr and wdata into internal registers, update the pointer, go to ISSUE.
  - No valid: stay in IDLE.
  - A requester may drop valid while in IDLE without consequence.
- ISSUE, exactly one cycle:
  - reqN_ready=1 for the granted requester.
  - rf_address = latched address.
  - In-range write: rf_write_en=1, rf_wr_data = latched data, next state RESP.
  - In-range read: rf_read_en=1, next state WAIT_RD.
  - Error (addr > MAX_ADDR, or protected write): no strobe, next state RESP with the error flag set.
- WAIT_RD:
  - Stays RD_LATENCY cycles.
  - rf_rd_data is captured into the response register on the edge ending the last WAIT_RD cycle; then go to RESP.
- RESP, one cycle:
  - reqN_rvalid=1.
  - reqN_rdata = captured data for reads, 0 for writes and errors.
  - reqN_err as decided in ISSUE.
  - Next state IDLE.
- Latency, counted from cycle 0 = IDLE with valid:
  - Ready in cycle 1.
  - Write rvalid in cycle 2.
  - Read rvalid in cycle 2+RD_LATENCY.
- Throughput: one transaction per 3 cycles for writes, 3+RD_LATENCY for reads.
- Granted fields are latched. Requester input changes after grant are ignored; the new request is seen on the next IDLE.
- Non-granted requester outputs stay 0 throughout.
- rf_address holds the last latched address between transactions.
- Strobes are never high outside ISSUE.
- Address 0 and broadcast addresses 0x01–0x03 pass through as normal writes; their decoding is the register file's responsibility.
- A read of a status register returns the value registered at the read strobe.

Optional Feature:
- Macro: RF_ARB_WPROT_EN.
- Defined: a requester-1 write with addr < WPROT_BASE gets ready, no rf_write_en, then rvalid with err=1 and rdata=0. Requester-1 reads and all requester-0 accesses are unaffected.
- Undefined: requester 1 may write any in-range address; err is raised only for out-of-range addresses.

Decomposition:
- Shared package/header rf_arb_pkg:
  - FSM state encodings.
  - Constants RF_MAX_ADDR=6'h38, RF_WPROT_BASE=6'h30, RF_BCAST_ALL=6'h01, RF_BCAST_ROT=6'h02, RF_BCAST_DRV=6'h03.
- One sub-module, rr_arb2: a two-input round-robin picker. Inputs: two requests, last-served pointer, update enable. Outputs: one-hot grant and the next pointer.

Test Plan:
- Write after reset: req0 write addr 0x04 data 0xA5.
  - Response: req0_ready in cycle 1.
  - Same cycle: rf_write_en=1, rf_address=0x04, rf_wr_data=0xA5.
  - req0_rvalid=1 in cycle 2 with err=0.
- Read, RD_LATENCY=1: req1 read 0x0F, model returns 0x3C one cycle after rf_read_en.
  - Response: req1_rvalid in cycle 3 with rdata=0x3C, err=0.
- Simultaneous requests, both held valid for several transactions.
  - Response: grants alternate req0, req1, req0, req1.
  - Exactly one strobe per ISSUE; no rvalid on the non-granted side.
- Out-of-range access: req0 read 0x3A.
  - Response: ready, no rf_read_en, rvalid with err=1 and rdata=0x00.
- With RF_ARB_WPROT_EN: req1 write 0x0C.
  - Response: no rf_write_en, err=1.
  - req1 write 0x38 data 0x1F is issued with err=0.
- Reset mid-read: reset_n low during WAIT_RD.
  - Response: all outputs 0 immediately.
  - After release, no stray rvalid.
  - Next simultaneous request is granted to req0.
